deint_sched: RTL and testbench
==============================

// Module: deint_sched
// PURPOSE
//  Commutator/address scheduler for the DVB convolutional deinterleaver (I=12, M=17).
//  Per-branch circular FIFOs in one shared single-port byte RAM; sequences read-then-write per symbol.
//  Sits between symbol input strobe (sym_ena/sym_din) and deinterleaved output (sym_vld/sym_dout); owns RAM.
// PARAMETERS
//  I        12    branch count; branch j delay = (I-1-j)*M symbols
//  M        17    unit delay
//  PKT_LEN  204   packet length (bytes), used by sync alignment only
//  DW       8     symbol width
//  AW       11    RAM address width, >= $clog2(M*I*(I-1)/2) (=1122 bytes)
// PORTS
//  clk        in   1    clock
//  rst        in   1    async reset, active-high
//  sym_ena    in   1    input symbol strobe, single-cycle
//  sym_din    in   DW   input symbol, valid with sym_ena
//  ram_addr   out  AW   RAM address
//  ram_re     out  1    RAM read strobe; ram_rdata valid next cycle
//  ram_we     out  1    RAM write strobe
//  ram_wdata  out  DW   RAM write data
//  ram_rdata  in   DW   RAM read data
//  sym_vld    out  1    output symbol valid, single-cycle
//  sym_dout   out  DW   deinterleaved symbol
//  branch     out  4    branch index of symbol in flight
//  busy       out  1    FSM not IDLE
//  sym_drop   out  1    pulse: sym_ena arrived while busy, symbol discarded
//  sync_lock  out  1    alignment locked (tied 1 without DEINT_SYNC_ALIGN_EN)
// BEHAVIOUR
//  Reset: all outputs 0 (sync_lock 1 if macro absent), branch=0, all ptr=0, primed=0, FSM IDLE.
//  FSM IDLE->RD->WR->IDLE. sym_ena sampled only in IDLE (T0): latch din, go RD.
//  RD (T1): ram_re=1, ram_addr=base[j]+ptr[j]. WR (T2): ram_we=1, same addr, ram_wdata=latched din;
//   sym_dout<=ram_rdata, sym_vld<=primed[j] -> visible T3. Latency ena->vld = 3 cycles.
//  base[j] = M*sum_{k<j}(I-1-k); depth[j]=(I-1-j)*M. ptr[j] wraps depth[j]-1 -> 0; on wrap set primed[j].
//  Branch I-1 (depth 0): no ram_re/ram_we, sym_dout<=latched din, sym_vld=1; same 3-cycle latency.
//  After WR: branch wraps I-1 -> 0, else +1. Max accepted rate: 1 symbol / 3 cycles.
//  sym_ena in RD or WR: symbol ignored, sym_drop pulses next cycle, no state change.
//  ram_re and ram_we never high in same cycle. Mid-operation rst: abort, return to reset state.
// CONFIGURATION
//  DEINT_SYNC_ALIGN_EN defined: packet counter 0..PKT_LEN-1 advances per accepted symbol.
//   Unlocked: accepted din==8'h47 or 8'hB8 forces branch=0, counter=0, sync_lock=1 (symbol processed on branch 0).
//   Locked: at counter==0 missing sync counts miss; 3 consecutive misses -> sync_lock=0. Sync resets miss count.
//  Not defined: branch free-runs from reset, no counter, sync_lock=1 constant.
// STRUCTURE
//  deint_pkg: state enum {IDLE,RD,WR}, SYNC_BYTE/SYNC_BYTE_INV, function base_addr(j), depth(j).
//  Sub-module deint_ptr_bank: I pointer regs + primed bits; inputs branch, adv; outputs ptr, primed.
// TESTING
//  Reset, ena din=0x11 -> T1 ram_re=1 addr=0 branch=0; T2 ram_we=1 wdata=0x11; T3 sym_vld=0.
//  12th symbol din=0xAB (branch 11) -> no RAM strobes, T3 sym_vld=1 sym_dout=0xAB.
//  Symbols 0..2244 with din=index[7:0]; symbol 2244 (branch 0, ptr wrapped) -> vld=1 dout=0x00.
//  ena at T0 and T1 -> second ignored, sym_drop=1 at T2, branch advances once.
//  rst mid-RD -> outputs 0, next ena uses branch 0 addr 0.
//  Full 12*11*17*204-symbol interleaved file, ena every 3 cycles -> vld stream matches golden, no drops.
//  Macro on: 0x47 on symbol 5 while unlocked -> branch=0, sync_lock=1; 3 missed syncs -> sync_lock=0.

Source files
------------

// File: rtl/deint_pkg.sv
// Shared constants, FSM state type and branch geometry helpers for the
// DVB convolutional deinterleaver scheduler (I=12 branches, M=17 unit delay).
package deint_pkg;

    localparam int I       = 12;   // branch count
    localparam int M       = 17;   // unit delay
    localparam int PKT_LEN = 204;  // packet length in bytes (sync alignment)
    localparam int DW      = 8;    // symbol width
    localparam int AW      = 11;   // RAM address width (1122 bytes used)
    localparam int BW      = 4;    // branch index width
    localparam int PW      = 8;    // per-branch pointer width (max depth 187)
    localparam int CW      = 8;    // packet counter width

    localparam logic [BW-1:0] LAST_BR       = BW'(I - 1);
    localparam logic [DW-1:0] SYNC_BYTE     = 8'h47;
    localparam logic [DW-1:0] SYNC_BYTE_INV = 8'hB8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    // First RAM byte of branch j: M * sum_{k<j} (I-1-k).
    function automatic logic [AW-1:0] base_addr(input logic [BW-1:0] j);
        int sum;
        sum = 0;
        for (int k = 0; k < I; k++) begin
            if (k < int'(j)) sum += (I - 1 - k) * M;
        end
        return AW'(sum);
    endfunction

    // FIFO depth of branch j: (I-1-j) * M; zero for the last branch.
    function automatic logic [PW-1:0] depth(input logic [BW-1:0] j);
        int d;
        d = (int'(j) < I) ? (I - 1 - int'(j)) * M : 0;
        return PW'(d);
    endfunction

endpackage

// File: rtl/deint_sched_if.sv
// Symbol input, deinterleaved output, status and RAM bus of the scheduler.
// slave: scheduler side. master: symbol source / output sink / RAM side.
interface deint_sched_if;
    import deint_pkg::*;

    logic          sym_ena;
    logic [DW-1:0] sym_din;
    logic [AW-1:0] ram_addr;
    logic          ram_re;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          sym_vld;
    logic [DW-1:0] sym_dout;
    logic [BW-1:0] branch;
    logic          busy;
    logic          sym_drop;
    logic          sync_lock;

    modport slave (
        input  sym_ena, sym_din, ram_rdata,
        output ram_addr, ram_re, ram_we, ram_wdata,
        output sym_vld, sym_dout, branch, busy, sym_drop, sync_lock
    );

    modport master (
        output sym_ena, sym_din, ram_rdata,
        input  ram_addr, ram_re, ram_we, ram_wdata,
        input  sym_vld, sym_dout, branch, busy, sym_drop, sync_lock
    );

endinterface

// File: rtl/deint_ptr_bank.sv
// Per-branch circular write/read pointers and "primed" flags. A branch is
// primed once its pointer has wrapped, i.e. its FIFO holds real data.
module deint_ptr_bank
    import deint_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] sel,
    input  logic          adv,
    output logic [PW-1:0] ptr,
    output logic          primed
);

    logic [PW-1:0] ptr_q [I];
    logic [I-1:0]  primed_q;
    logic [PW-1:0] last_idx;

    assign last_idx = depth(sel) - PW'(1);
    assign ptr      = ptr_q[sel];
    assign primed   = primed_q[sel];

    // Advance the selected branch pointer, wrapping at its depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this is a small register file, not a RAM; every entry must
            // be reset because the pointers define where each FIFO starts.
            for (int k = 0; k < I; k++) ptr_q[k] <= '0;
            primed_q <= '0;
        end else if (adv) begin
            if (ptr_q[sel] == last_idx) begin
                ptr_q[sel]    <= '0;
                primed_q[sel] <= 1'b1;
            end else begin
                ptr_q[sel] <= ptr_q[sel] + PW'(1);
            end
        end
    end

endmodule

// File: rtl/deint_sched.sv
// Commutator / RAM address scheduler for the DVB convolutional deinterleaver.
// Each accepted symbol does one read-then-write on its branch FIFO slot.
// Optional feature: define DEINT_SYNC_ALIGN_EN to align the commutator to
// packet sync bytes (0x47 / 0xB8); otherwise branch free-runs from reset.
module deint_sched
    import deint_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    deint_sched_if.slave bus
);

    state_t        state;
    logic [BW-1:0] branch_q;
    logic [BW-1:0] eff_branch;
    logic [BW-1:0] cur_branch;
    logic [DW-1:0] din_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] dout_q;
    logic          re_q, we_q, vld_q, drop_q;
    logic [PW-1:0] cur_ptr;
    logic          cur_primed;
    logic          ptr_adv;
    logic [AW-1:0] rd_addr;
    logic          lock;

`ifdef DEINT_SYNC_ALIGN_EN
    logic [CW-1:0] pkt_cnt;
    logic [1:0]    miss_cnt;
    logic          accept;
    logic          is_sync;
    logic [CW-1:0] pkt_cnt_nxt;

    assign accept      = (state == IDLE) && bus.sym_ena;
    assign is_sync     = (bus.sym_din == SYNC_BYTE) || (bus.sym_din == SYNC_BYTE_INV);
    assign eff_branch  = (!lock && is_sync) ? '0 : branch_q;
    assign pkt_cnt_nxt = (pkt_cnt == CW'(PKT_LEN - 1)) ? '0 : pkt_cnt + CW'(1);

    // Packet position tracking: acquire on any sync byte, drop lock after
    // three consecutive packet starts without one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt  <= '0;
            miss_cnt <= '0;
            lock     <= 1'b0;
        end else if (accept) begin
            if (!lock) begin
                if (is_sync) begin
                    lock     <= 1'b1;
                    miss_cnt <= '0;
                    pkt_cnt  <= (PKT_LEN > 1) ? CW'(1) : '0;
                end else begin
                    pkt_cnt <= pkt_cnt_nxt;
                end
            end else begin
                if (pkt_cnt == '0) begin
                    if (is_sync) begin
                        miss_cnt <= '0;
                    end else if (miss_cnt == 2'd2) begin
                        miss_cnt <= '0;
                        lock     <= 1'b0;
                    end else begin
                        miss_cnt <= miss_cnt + 2'd1;
                    end
                end
                pkt_cnt <= pkt_cnt_nxt;
            end
        end
    end
`else
    assign eff_branch = branch_q;
    assign lock       = 1'b1;
`endif

    // The incoming symbol's branch is only known combinationally in IDLE;
    // afterwards the registered branch selects the pointer.
    assign cur_branch = (state == IDLE) ? eff_branch : branch_q;
    assign rd_addr    = base_addr(eff_branch) + AW'(cur_ptr);
    assign ptr_adv    = (state == WR) && (branch_q != LAST_BR);

    deint_ptr_bank u_ptr_bank (
        .clk    (clk),
        .rst    (rst),
        .sel    (cur_branch),
        .adv    (ptr_adv),
        .ptr    (cur_ptr),
        .primed (cur_primed)
    );

    // IDLE -> RD -> WR -> IDLE sequencer with registered RAM and symbol outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            branch_q <= '0;
            din_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dout_q   <= '0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            vld_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every branch below sees the
            // pre-edge values; these defaults make the strobes single-cycle.
            re_q   <= 1'b0;
            we_q   <= 1'b0;
            vld_q  <= 1'b0;
            drop_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.sym_ena) begin
                        din_q    <= bus.sym_din;
                        branch_q <= eff_branch;
                        state    <= RD;
                        if (eff_branch != LAST_BR) begin
                            re_q   <= 1'b1;
                            addr_q <= rd_addr;
                        end
                    end
                end
                RD: begin
                    drop_q <= bus.sym_ena;
                    state  <= WR;
                    if (branch_q != LAST_BR) begin
                        we_q    <= 1'b1;
                        wdata_q <= din_q;
                    end
                end
                WR: begin
                    drop_q <= bus.sym_ena;
                    state  <= IDLE;
                    if (branch_q == LAST_BR) begin
                        dout_q   <= din_q;
                        vld_q    <= 1'b1;
                        branch_q <= '0;
                    end else begin
                        dout_q   <= bus.ram_rdata;
                        vld_q    <= cur_primed;
                        branch_q <= branch_q + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ram_addr  = addr_q;
    assign bus.ram_re    = re_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.sym_vld   = vld_q;
    assign bus.sym_dout  = dout_q;
    assign bus.branch    = branch_q;
    assign bus.busy      = (state != IDLE);
    assign bus.sym_drop  = drop_q;
    assign bus.sync_lock = lock;

endmodule

// File: tb/tb_deint_sched.sv
// Directed bench for deint_sched: reset state, first-symbol timing, the
// depth-0 branch, drop behaviour, mid-operation reset and a 2245-symbol
// stream compared against a branch-delay reference model.
module tb_deint_sched;
    import deint_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    deint_sched_if bus ();

    deint_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single-port RAM model: read data valid the cycle after ram_re.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
    end

    int drop_cnt    = 0;
    int overlap_cnt = 0;
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.sym_drop) drop_cnt++;
            if (bus.ram_re && bus.ram_we) overlap_cnt++;
        end
    end

    int checks   = 0;
    int failures = 0;

`ifdef DEINT_SYNC_ALIGN_EN
    localparam logic EXP_LOCK_RST = 1'b0;
`else
    localparam logic EXP_LOCK_RST = 1'b1;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic          t1_re, t1_we, t1_busy;
        logic [AW-1:0] t1_addr;
        logic [BW-1:0] t1_br;
        logic          t2_re, t2_we, t2_drop;
        logic [DW-1:0] t2_wd;
        logic          t3_vld, t3_busy;
        logic [DW-1:0] t3_dout;
        logic [BW-1:0] t3_br;
    } snap_t;

    // Called at a negedge with the DUT idle; returns at the negedge of T3,
    // so back-to-back calls present sym_ena every third cycle.
    task automatic run_sym(input logic [DW-1:0] din, output snap_t s);
        bus.sym_ena = 1'b1;
        bus.sym_din = din;
        @(negedge clk);
        bus.sym_ena = 1'b0;
        s.t1_re = bus.ram_re;  s.t1_we = bus.ram_we;  s.t1_busy = bus.busy;
        s.t1_addr = bus.ram_addr;  s.t1_br = bus.branch;
        @(negedge clk);
        s.t2_re = bus.ram_re;  s.t2_we = bus.ram_we;  s.t2_drop = bus.sym_drop;
        s.t2_wd = bus.ram_wdata;
        @(negedge clk);
        s.t3_vld = bus.sym_vld;  s.t3_dout = bus.sym_dout;
        s.t3_br = bus.branch;  s.t3_busy = bus.busy;
    endtask

    initial begin
        snap_t s;
        int    drops0;
        int    j, v, d;
        logic  exp_vld;
        logic [DW-1:0] exp_dout;

        bus.sym_ena = 1'b0;
        bus.sym_din = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_ram_re",   bus.ram_re,    0);
        check("rst_ram_we",   bus.ram_we,    0);
        check("rst_ram_addr", bus.ram_addr,  0);
        check("rst_wdata",    bus.ram_wdata, 0);
        check("rst_vld",      bus.sym_vld,   0);
        check("rst_dout",     bus.sym_dout,  0);
        check("rst_branch",   bus.branch,    0);
        check("rst_busy",     bus.busy,      0);
        check("rst_drop",     bus.sym_drop,  0);
        check("rst_lock",     bus.sync_lock, EXP_LOCK_RST);

        rst = 1'b0;
        @(negedge clk);

        // First symbol, branch 0, read/write slot 0, FIFO not primed
        run_sym(8'h11, s);
        check("s0_t1_re",   s.t1_re,   1);
        check("s0_t1_we",   s.t1_we,   0);
        check("s0_t1_addr", s.t1_addr, 0);
        check("s0_t1_br",   s.t1_br,   0);
        check("s0_t1_busy", s.t1_busy, 1);
        check("s0_t2_re",   s.t2_re,   0);
        check("s0_t2_we",   s.t2_we,   1);
        check("s0_t2_wd",   s.t2_wd,   8'h11);
        check("s0_t3_vld",  s.t3_vld,  0);
        check("s0_t3_br",   s.t3_br,   1);
        check("s0_t3_busy", s.t3_busy, 0);

        // Symbols 1..10, then branch 11 passes straight through
        for (int i = 1; i <= 10; i++) run_sym(8'(i), s);
        run_sym(8'hAB, s);
        check("b11_t1_re",  s.t1_re,   0);
        check("b11_t1_br",  s.t1_br,   11);
        check("b11_t2_we",  s.t2_we,   0);
        check("b11_t3_vld", s.t3_vld,  1);
        check("b11_t3_dout", s.t3_dout, 8'hAB);
        check("b11_t3_br",  s.t3_br,   0);

        // sym_ena held into RD: second symbol dropped, branch advances once
        bus.sym_ena = 1'b1;
        bus.sym_din = 8'h22;
        @(negedge clk);
        check("drop_t1_drop", bus.sym_drop, 0);
        check("drop_t1_addr", bus.ram_addr, 1);
        bus.sym_din = 8'h33;
        @(negedge clk);
        bus.sym_ena = 1'b0;
        check("drop_t2_drop", bus.sym_drop,  1);
        check("drop_t2_we",   bus.ram_we,    1);
        check("drop_t2_wd",   bus.ram_wdata, 8'h22);
        @(negedge clk);
        check("drop_t3_drop", bus.sym_drop, 0);
        check("drop_t3_br",   bus.branch,   1);
        check("drop_t3_busy", bus.busy,     0);

        // Reset while in RD (branch 1, slot 1 -> addr 187+1)
        bus.sym_ena = 1'b1;
        bus.sym_din = 8'h55;
        @(negedge clk);
        bus.sym_ena = 1'b0;
        check("mrst_pre_re",   bus.ram_re,   1);
        check("mrst_pre_addr", bus.ram_addr, 188);
        rst = 1'b1;
        #1;
        check("mrst_re",     bus.ram_re,   0);
        check("mrst_busy",   bus.busy,     0);
        check("mrst_branch", bus.branch,   0);
        check("mrst_addr",   bus.ram_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_sym(8'h66, s);
        check("mrst_next_re",   s.t1_re,   1);
        check("mrst_next_addr", s.t1_addr, 0);
        check("mrst_next_br",   s.t1_br,   0);

        // Stream 2245 symbols at full rate against a branch-delay model:
        // symbol n on branch j appears delayed by (11-j)*17 visits of j.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drops0 = drop_cnt;
        for (int n = 0; n <= 2244; n++) begin
            run_sym(8'(n), s);
            j = n % I;
            v = n / I;
            d = (I - 1 - j) * M;
            exp_vld  = (v >= d);
            exp_dout = 8'(n - I * d);
            check("stream_vld", s.t3_vld, exp_vld);
            check("stream_re",  s.t1_re,  (j != I - 1));
            if (exp_vld) check("stream_dout", s.t3_dout, exp_dout);
            if (n == 2244) begin
                check("s2244_br",   s.t1_br,   0);
                check("s2244_addr", s.t1_addr, 0);
                check("s2244_vld",  s.t3_vld,  1);
                check("s2244_dout", s.t3_dout, 8'h00);
            end
        end
        check("stream_no_drops", drop_cnt - drops0, 0);
        check("no_re_we_overlap", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
